// File: rtl/rolling_variance.sv
// rolling_variance: rolling-window variance radicand feeding a sqrt unit over a start/busy handshake.
// Define ROLLING_VARIANCE_SAT_EN to clamp an out-of-range radicand to all ones instead of wrapping.
module rolling_variance #(
  parameter int WIDTH  = 32,
  parameter int FBITS  = 16,
  parameter int DWIDTH = 8,
  parameter int LOG2_N = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_sample,
  input  logic              i_busy,
  output logic              o_start,
  output logic [WIDTH-1:0]  o_rad,
  output logic              o_warm
);
  localparam int N    = 1 << LOG2_N;
  localparam int SUMW = DWIDTH + LOG2_N;
  localparam int SQW  = 2 * DWIDTH + LOG2_N;
  localparam int NW   = 2 * DWIDTH + 2 * LOG2_N;
  localparam int XW   = (NW + FBITS > WIDTH) ? NW + FBITS : WIDTH + 1;
  typedef enum logic [1:0] {IDLE, MUL, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic [DWIDTH-1:0] win [N];
  logic [LOG2_N-1:0] wr_ptr;
  logic [LOG2_N:0]   fill;
  logic [SUMW-1:0]   sum, sum_s;
  logic [SQW-1:0]    sumsq, sumsq_s;
  logic [NW-1:0]     num;
  logic [DWIDTH-1:0] old;
  logic [WIDTH-1:0]  rad_n;
  logic              pending, snap;
  assign o_warm = fill == (LOG2_N + 1)'(N);
  assign old    = o_warm ? win[wr_ptr] : '0;
  assign snap   = state == IDLE && pending && o_warm;
`ifdef ROLLING_VARIANCE_SAT_EN
  logic [XW-1:0] scaled;
  assign scaled = XW'({num, {FBITS{1'b0}}}) >> (2 * LOG2_N);
  assign rad_n  = |scaled[XW-1:WIDTH] ? '1 : scaled[WIDTH-1:0];
`else
  assign rad_n  = WIDTH'(XW'({num, {FBITS{1'b0}}}) >> (2 * LOG2_N));
`endif
  // window contents need no reset: fill masks stale entries until N fresh samples land
  always_ff @(posedge i_clk)
    if (i_valid) win[wr_ptr] <= i_sample;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (snap ? MUL : IDLE) :
              state == MUL   ? ISSUE :
              state == ISSUE ? (i_busy ? ISSUE : HOLD) : IDLE;
  always_comb o_start = state == HOLD;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_ptr  <= '0;
      fill    <= '0;
      sum     <= '0;
      sumsq   <= '0;
      pending <= 1'b0;
      sum_s   <= '0;
      sumsq_s <= '0;
      num     <= '0;
      o_rad   <= '0;
    end else begin
      if (i_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= o_warm ? fill : fill + 1'b1;
        sum    <= sum + SUMW'(i_sample) - SUMW'(old);
        sumsq  <= sumsq + SQW'(i_sample) * SQW'(i_sample) - SQW'(old) * SQW'(old);
      end
      // a sample landing on the snapshot edge keeps pending so the newer window is computed next
      pending <= i_valid | (pending & ~snap);
      if (snap) begin
        sum_s   <= sum;
        sumsq_s <= sumsq;
      end
      if (state == MUL) num <= (NW'(sumsq_s) << LOG2_N) - NW'(sum_s) * NW'(sum_s);
      if (state == ISSUE && !i_busy) o_rad <= rad_n;
    end
endmodule
